data_mem_dump: RTL and testbench
================================

Name: data_mem_dump

Overview:
Debug-side reader of the data RAM that the MEM stage writes. After the pipeline halts, the debug unit pulses start. The block then reads data-RAM words 0..num_words-1 through the RAM port and serialises each 32-bit word into 4 bytes, MSB first. The bytes go to the UART transmitter over a start/done handshake, and a one-cycle done pulse marks the end of the dump.

Parameters:
RAM_WIDTH, 32, data word width; must be a multiple of 8.
RAM_DEPTH, 2048, number of words in the data RAM.
AW, $clog2(RAM_DEPTH), RAM address width.
READ_LATENCY, 1, cycles from mem_en/mem_addr to valid mem_data. Use 1 for LOW_LATENCY RAM and 2 for HIGH_PERFORMANCE RAM.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
num_words  input  AW+1  number of words to dump; sampled together with start
mem_addr  output  AW  RAM read address
mem_en  output  1  RAM read enable
mem_data  input  RAM_WIDTH  RAM read data
tx_data  output  8  byte for the UART transmitter
tx_start  output  1  one-cycle pulse: transmitter loads tx_data
tx_done  input  1  one-cycle pulse from the transmitter: byte fully sent
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the dump completes

Behaviour:
- All outputs are registered.
- Reset values: mem_addr=0, mem_en=0, tx_data=0, tx_start=0, busy=0, done=0. The FSM goes to IDLE, and the word and byte counters clear.
- Reset has priority over every other input in the same cycle.
- FSM states: IDLE, READ, WAIT, SEND, WAIT_TX, DONE.
- IDLE:
  - On start=1, latch cnt = min(num_words, RAM_DEPTH) and clear word_idx.
  - If cnt=0, go to DONE.
  - Otherwise go to READ.
  - start outside IDLE is ignored.
- READ: exactly 1 cycle. mem_en=1 and mem_addr=word_idx. Go to WAIT.
- WAIT:
  - Lasts READ_LATENCY cycles.
  - mem_en stays 1 and mem_addr is held.
  - On the last WAIT cycle, capture mem_data into a word shift register and set byte_idx=0.
  - Then go to SEND.
- SEND: exactly 1 cycle.
  - tx_start=1.
  - tx_data = word[31:24] for byte_idx 0, [23:16] for 1, [15:8] for 2, [7:0] for 3.
  - Go to WAIT_TX.
- WAIT_TX:
  - tx_data is held stable; tx_start=0.
  - Stay here until tx_done=1.
  - On tx_done with byte_idx<3: byte_idx+1, go to SEND.
  - On tx_done with byte_idx=3 and word_idx+1<cnt: word_idx+1, go to READ.
  - On tx_done with byte_idx=3 on the last word: go to DONE.
- DONE: exactly 1 cycle. done=1 and busy=1. Then go to IDLE.
- mem_en=0 outside READ and WAIT.
- Timing: with start sampled at edge t, READ occupies cycle t+1 and the first tx_start is in cycle t+2+READ_LATENCY.
- Between bytes of the same word, tx_start rises on the cycle after tx_done.
- Between words, tx_start rises 2+READ_LATENCY cycles after tx_done.
- tx_done arriving in any state other than WAIT_TX is ignored; it never advances the counters.
- Addresses run 0..cnt-1 with no wrap-around. word_idx never exceeds RAM_DEPTH-1.
- If num_words > RAM_DEPTH, it is clamped to RAM_DEPTH words.
- The block never writes the RAM: it drives no we signal, and the RAM we is owned by the MEM stage.
- Reset mid-dump:
  - All state is abandoned.
  - tx_start, busy and done drop on the next cycle.
  - No done pulse is produced.
  - A following start begins again at address 0.

Test Plan:
- Basic dump: RAM[0]=0xDEADBEEF, RAM[1]=0x01234567, num_words=2, tx_done returned 5 cycles after each tx_start -> tx_data sequence DE AD BE EF 01 23 45 67; mem_addr 0 then 1; exactly 8 tx_start pulses; done pulse once after the 8th tx_done; busy then drops to 0.
- Latency: READ_LATENCY=1, start at edge t -> mem_en=1 in cycles t+1..t+2 and tx_start=1 in cycle t+3. Repeat with READ_LATENCY=2 -> tx_start=1 in cycle t+4.
- Zero and clamp: num_words=0 -> no mem_en and no tx_start, done in cycle t+1. num_words=4095 with RAM_DEPTH=2048 -> last mem_addr=2047 and 8192 bytes sent.
- Spurious inputs: start pulsed while in WAIT_TX -> ignored, byte count unchanged. tx_done pulsed in IDLE or SEND -> byte_idx unchanged, no byte skipped.
- Reset mid-operation: assert reset after the 3rd tx_done of word 0 -> next cycle all outputs 0 and no done pulse. A new start with num_words=1 re-sends DE AD BE EF from address 0.
- Back-to-back: start asserted in the cycle after the done pulse -> accepted, and a second full dump follows with identical byte order.

Source files
------------

// File: rtl/data_mem_dump_if.sv
// Bus bundle between the data-RAM dump engine and its environment: RAM read port,
// UART transmit handshake, and the debug unit's start/status signals.
interface data_mem_dump_if #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 2048,
  parameter int AW        = $clog2(RAM_DEPTH)
);
  logic                 start;
  logic [AW:0]          num_words;
  logic [AW-1:0]        mem_addr;
  logic                 mem_en;
  logic [RAM_WIDTH-1:0] mem_data;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_done;
  logic                 busy;
  logic                 done;

  // The dump engine drives the RAM address/enable and the transmitter request.
  modport master (
    input  start, num_words, mem_data, tx_done,
    output mem_addr, mem_en, tx_data, tx_start, busy, done
  );

  modport slave (
    output start, num_words, mem_data, tx_done,
    input  mem_addr, mem_en, tx_data, tx_start, busy, done
  );
endinterface

// File: rtl/data_mem_dump.sv
// Reads data-RAM words 0..cnt-1 after a halt and streams each word to the UART
// transmitter as bytes, most significant byte first.
module data_mem_dump #(
  parameter int RAM_WIDTH    = 32,
  parameter int RAM_DEPTH    = 2048,
  parameter int AW           = $clog2(RAM_DEPTH),
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_dump_if.master bus
);

  localparam int BYTES = RAM_WIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int LW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(READ_LATENCY - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(RAM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_WAIT_TX,
    S_DONE
  } state_t;

  state_t               state;
  logic [AW:0]          cnt;
  logic [AW-1:0]        word_idx;
  logic [BW-1:0]        byte_idx;
  logic [LW-1:0]        lat_cnt;
  logic [RAM_WIDTH-1:0] word_sr;
  logic [AW:0]          next_word;

  // One bit wider than the address so the last-word compare cannot wrap.
  assign next_word = {1'b0, word_idx} + (AW + 1)'(1);

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      lat_cnt      <= '0;
      word_sr      <= '0;
      bus.mem_addr <= '0;
      bus.mem_en   <= 1'b0;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt      <= (bus.num_words > DEPTH_W) ? DEPTH_W : bus.num_words;
            word_idx <= '0;
            bus.busy <= 1'b1;
            if (bus.num_words == '0) begin
              bus.done <= 1'b1;
              state    <= S_DONE;
            end else begin
              bus.mem_en   <= 1'b1;
              bus.mem_addr <= '0;
              state        <= S_READ;
            end
          end
        end

        S_READ: begin
          lat_cnt <= '0;
          state   <= S_WAIT;
        end

        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            // Top byte goes straight out; the rest is pre-shifted for later bytes.
            bus.tx_data  <= bus.mem_data[RAM_WIDTH-1 -: 8];
            word_sr      <= bus.mem_data << 8;
            byte_idx     <= '0;
            bus.mem_en   <= 1'b0;
            bus.tx_start <= 1'b1;
            state        <= S_SEND;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end

        S_SEND: begin
          bus.tx_start <= 1'b0;
          state        <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (bus.tx_done) begin
            if (byte_idx != BYTE_LAST) begin
              byte_idx     <= byte_idx + BW'(1);
              bus.tx_data  <= word_sr[RAM_WIDTH-1 -: 8];
              word_sr      <= word_sr << 8;
              bus.tx_start <= 1'b1;
              state        <= S_SEND;
            end else if (next_word < cnt) begin
              word_idx     <= next_word[AW-1:0];
              bus.mem_addr <= next_word[AW-1:0];
              bus.mem_en   <= 1'b1;
              state        <= S_READ;
            end else begin
              bus.done <= 1'b1;
              state    <= S_DONE;
            end
          end
        end

        S_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_dump.sv
// Scoreboard bench for data_mem_dump: expected bytes/addresses are queued at stimulus
// time and popped by a monitor whenever the DUT issues tx_start or a new RAM read.
module tb_data_mem_dump;

  logic clk;
  logic reset_base;
  logic rst1;

  data_mem_dump_if #(.RAM_WIDTH(32), .RAM_DEPTH(2048)) bus1 ();
  data_mem_dump_if #(.RAM_WIDTH(32), .RAM_DEPTH(16))   bus2 ();

  data_mem_dump #(.RAM_WIDTH(32), .RAM_DEPTH(2048), .READ_LATENCY(1)) u_dut (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  data_mem_dump #(.RAM_WIDTH(32), .RAM_DEPTH(16), .READ_LATENCY(2)) u_dut2 (
    .clk   (clk),
    .reset (reset_base),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // RAM models: latency 1 for u_dut, latency 2 for u_dut2
  logic [31:0] ram  [2048];
  logic [31:0] ram2 [16];
  logic [31:0] mem_q, p1, p2;

  always @(posedge clk) if (bus1.mem_en) mem_q <= ram[bus1.mem_addr];
  always @(posedge clk) begin
    if (bus2.mem_en) p1 <= ram2[bus2.mem_addr];
    p2 <= p1;
  end
  assign bus1.mem_data = mem_q;
  assign bus2.mem_data = p2;

  // Transmitter model for u_dut: tx_done tx_lat cycles after each tx_start
  int   tx_lat    = 5;
  bit   spur_send = 1'b0;
  int   rst_at    = 0;
  int   txd_cnt   = 0;
  int   cd        = 0;
  logic resp_done = 1'b0;
  logic resp_rst  = 1'b0;
  logic spur_done = 1'b0;

  assign bus1.tx_done = resp_done | spur_done;
  assign rst1         = reset_base | resp_rst;

  always @(negedge clk) begin
    resp_done = 1'b0;
    resp_rst  = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        resp_done = 1'b1;
        txd_cnt++;
        if (rst_at != 0 && txd_cnt == rst_at) resp_rst = 1'b1;
      end
    end
    if (bus1.tx_start) begin
      cd = tx_lat;
      if (spur_send) resp_done = 1'b1;
    end
  end

  // Scoreboard
  logic [7:0]  exp_q  [$];
  logic [10:0] addr_q [$];
  int          tx_cnt    = 0;
  int          done_cnt  = 0;
  int          last_addr = -1;
  logic        en_d      = 1'b0;

  always @(negedge clk) begin
    if (bus1.tx_start) begin
      tx_cnt++;
      check("tx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("tx_data", 32'(bus1.tx_data), 32'(exp_q.pop_front()));
    end
    if (bus1.mem_en && !en_d) begin
      last_addr = int'(bus1.mem_addr);
      check("read_expected", 32'(addr_q.size() != 0), 32'd1);
      if (addr_q.size() != 0) check("mem_addr", 32'(bus1.mem_addr), 32'(addr_q.pop_front()));
    end
    en_d = bus1.mem_en;
    if (bus1.done) done_cnt++;
  end

  task automatic push_word(input logic [31:0] w, input logic [10:0] a, input int nbytes);
    logic [31:0] s;
    s = w;
    addr_q.push_back(a);
    for (int k = 0; k < nbytes; k++) begin
      exp_q.push_back(s[31:24]);
      s = s << 8;
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after start was sampled
  task automatic pulse_start(input int n);
    bus1.start     = 1'b1;
    bus1.num_words = 12'(n);
    @(negedge clk);
    bus1.start     = 1'b0;
    bus1.num_words = '0;
  endtask

  // Waits for done, then checks counts at the negedge of the following (IDLE) cycle
  task automatic finish_dump(input string tag, input int t0, input int d0,
                             input int n_bytes, input int budget);
    int n;
    n = 0;
    while (!bus1.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(bus1.done), 32'd1);
    @(negedge clk);
    check({tag, "_busy_low"}, 32'(bus1.busy), 32'd0);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_byte_count"}, 32'(tx_cnt - t0), 32'(n_bytes));
    check({tag, "_queue_empty"}, 32'(exp_q.size() + addr_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"}, 32'(bus1.mem_addr), 32'd0);
    check({tag, "_mem_en"},   32'(bus1.mem_en),   32'd0);
    check({tag, "_tx_data"},  32'(bus1.tx_data),  32'd0);
    check({tag, "_tx_start"}, 32'(bus1.tx_start), 32'd0);
    check({tag, "_busy"},     32'(bus1.busy),     32'd0);
    check({tag, "_done"},     32'(bus1.done),     32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d0, n;
    logic [31:0] w2;

    reset_base     = 1'b1;
    bus1.start     = 1'b0;
    bus1.num_words = '0;
    bus2.start     = 1'b0;
    bus2.num_words = '0;
    bus2.tx_done   = 1'b0;
    for (int i = 0; i < 2048; i++) ram[i] = 32'(i) * 32'h9E3779B1;
    ram[0] = 32'hDEADBEEF;
    ram[1] = 32'h01234567;
    for (int i = 0; i < 16; i++) ram2[i] = 32'h0;
    ram2[0] = 32'hCAFEF00D;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_base = 1'b0;
    @(negedge clk);

    // Basic dump with latency checks on the first read
    push_word(32'hDEADBEEF, 11'd0, 4);
    push_word(32'h01234567, 11'd1, 4);
    t0 = tx_cnt; d0 = done_cnt;
    pulse_start(2);
    check("lat_read_en", 32'(bus1.mem_en), 32'd1);
    check("lat_read_busy", 32'(bus1.busy), 32'd1);
    @(negedge clk);
    check("lat_wait_en", 32'(bus1.mem_en), 32'd1);
    check("lat_wait_txs", 32'(bus1.tx_start), 32'd0);
    @(negedge clk);
    check("lat_send_txs", 32'(bus1.tx_start), 32'd1);
    check("lat_send_en", 32'(bus1.mem_en), 32'd0);
    finish_dump("basic", t0, d0, 8, 300);

    // Back-to-back: start in the cycle right after the done pulse
    push_word(32'hDEADBEEF, 11'd0, 4);
    push_word(32'h01234567, 11'd1, 4);
    t0 = tx_cnt; d0 = done_cnt;
    pulse_start(2);
    check("b2b_accepted", 32'(bus1.busy), 32'd1);
    finish_dump("b2b", t0, d0, 8, 300);

    // Zero words: done in the cycle after start, no reads, no bytes
    @(negedge clk);
    t0 = tx_cnt; d0 = done_cnt;
    pulse_start(0);
    check("zero_done", 32'(bus1.done), 32'd1);
    check("zero_busy", 32'(bus1.busy), 32'd1);
    check("zero_mem_en", 32'(bus1.mem_en), 32'd0);
    @(negedge clk);
    check("zero_done_drop", 32'(bus1.done), 32'd0);
    check("zero_busy_drop", 32'(bus1.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("zero_no_bytes", 32'(tx_cnt - t0), 32'd0);
    check("zero_done_count", 32'(done_cnt - d0), 32'd1);

    // Spurious start while in WAIT_TX
    push_word(32'hDEADBEEF, 11'd0, 4);
    t0 = tx_cnt; d0 = done_cnt;
    pulse_start(1);
    n = 0;
    while (!bus1.tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("spur_start_first_byte", 32'(bus1.tx_start), 32'd1);
    repeat (2) @(negedge clk);
    bus1.start     = 1'b1;
    bus1.num_words = 12'd2;
    @(negedge clk);
    bus1.start     = 1'b0;
    bus1.num_words = '0;
    finish_dump("spur_start", t0, d0, 4, 300);

    // Spurious tx_done in IDLE, then in every SEND cycle
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    spur_send = 1'b1;
    push_word(32'hDEADBEEF, 11'd0, 4);
    push_word(32'h01234567, 11'd1, 4);
    t0 = tx_cnt; d0 = done_cnt;
    pulse_start(2);
    finish_dump("spur_done", t0, d0, 8, 300);
    spur_send = 1'b0;

    // Reset asserted in the cycle of the 3rd tx_done of word 0
    exp_q.push_back(8'hDE);
    exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE);
    addr_q.push_back(11'd0);
    d0 = done_cnt;
    rst_at = txd_cnt + 3;
    pulse_start(2);
    n = 0;
    while (txd_cnt < rst_at && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("midrst_reached", 32'(txd_cnt >= rst_at), 32'd1);
    check_all_zero("midrst");
    rst_at = 0;
    repeat (20) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_queue_empty", 32'(exp_q.size() + addr_q.size()), 32'd0);

    push_word(32'hDEADBEEF, 11'd0, 4);
    t0 = tx_cnt; d0 = done_cnt;
    pulse_start(1);
    finish_dump("restart", t0, d0, 4, 300);

    // Clamp: 4095 words requested from a 2048-word RAM
    tx_lat = 1;
    for (int i = 0; i < 2048; i++) push_word(ram[i], 11'(i), 4);
    @(negedge clk);
    t0 = tx_cnt; d0 = done_cnt;
    pulse_start(4095);
    finish_dump("clamp", t0, d0, 8192, 40000);
    check("clamp_last_addr", 32'(last_addr), 32'd2047);

    // READ_LATENCY=2 instance: first tx_start at t+4, then manual tx_done
    w2 = 32'hCAFEF00D;
    @(negedge clk);
    bus2.start     = 1'b1;
    bus2.num_words = 5'd1;
    @(negedge clk);
    bus2.start     = 1'b0;
    bus2.num_words = '0;
    check("rl2_t1_en", 32'(bus2.mem_en), 32'd1);
    @(negedge clk);
    check("rl2_t2_en", 32'(bus2.mem_en), 32'd1);
    @(negedge clk);
    check("rl2_t3_en", 32'(bus2.mem_en), 32'd1);
    check("rl2_t3_txs", 32'(bus2.tx_start), 32'd0);
    @(negedge clk);
    check("rl2_t4_txs", 32'(bus2.tx_start), 32'd1);
    check("rl2_byte0", 32'(bus2.tx_data), 32'(w2[31:24]));
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      bus2.tx_done = 1'b1;
      @(negedge clk);
      bus2.tx_done = 1'b0;
      check("rl2_next_txs", 32'(bus2.tx_start), 32'd1);
      check("rl2_byte", 32'(bus2.tx_data), 32'(w2[31-8*k -: 8]));
    end
    @(negedge clk);
    bus2.tx_done = 1'b1;
    @(negedge clk);
    bus2.tx_done = 1'b0;
    check("rl2_done", 32'(bus2.done), 32'd1);
    @(negedge clk);
    check("rl2_busy_drop", 32'(bus2.busy), 32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
